// File: rtl/core_mem_access_unit.sv
// Data-memory access stage: req/gnt/rvalid handshake with data memory,
// core stall while the access is in flight, and a bus timeout.
module core_mem_access_unit #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ls_valid_i,
  input  logic                      ls_we_i,
  input  logic [MEM_ADDR_WIDTH-1:0] ls_addr_i,
  input  logic [DATA_WIDTH-1:0]     ls_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   ls_be_i,
  output logic                      stall_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam logic [TIMEOUT_WIDTH-1:0] LP_LAST =
    TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_R,
    S_DONE
  } state_t;

  state_t                    r_state;
  logic [TIMEOUT_WIDTH-1:0]  r_cnt;
  logic                      r_req;
  logic                      r_we;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [BE_W-1:0]           r_be;
  logic [DATA_WIDTH-1:0]     r_rdata;
  logic                      r_done;
  logic                      r_err;

  state_t                    w_nxt_state;
  logic [TIMEOUT_WIDTH-1:0]  w_nxt_cnt;
  logic                      w_nxt_req;
  logic                      w_nxt_we;
  logic [MEM_ADDR_WIDTH-1:0] w_nxt_addr;
  logic [DATA_WIDTH-1:0]     w_nxt_wdata;
  logic [BE_W-1:0]           w_nxt_be;
  logic [DATA_WIDTH-1:0]     w_nxt_rdata;
  logic                      w_nxt_done;
  logic                      w_nxt_err;
  logic                      w_last;

  assign w_last = (r_cnt == LP_LAST);

  // Stall: pending request in IDLE, or an access still in flight.
  always_comb begin
    stall_o = 1'b0;
    unique case (r_state)
      S_IDLE:   stall_o = ls_valid_i;
      S_REQ:    stall_o = 1'b1;
      S_WAIT_R: stall_o = 1'b1;
      S_DONE:   stall_o = 1'b0;
      default:  stall_o = 1'b0;
    endcase
  end

  // Next-state and next-register values for the access FSM.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_req   = r_req;
    w_nxt_we    = r_we;
    w_nxt_addr  = r_addr;
    w_nxt_wdata = r_wdata;
    w_nxt_be    = r_be;
    w_nxt_rdata = r_rdata;
    w_nxt_done  = 1'b0;
    w_nxt_err   = r_err;
    unique case (r_state)
      S_IDLE: begin
        w_nxt_err = 1'b0;
        if (ls_valid_i) begin
          w_nxt_we    = ls_we_i;
          w_nxt_addr  = ls_addr_i;
          w_nxt_wdata = ls_wdata_i;
          w_nxt_be    = ls_be_i;
          w_nxt_req   = 1'b1;
          w_nxt_cnt   = '0;
          w_nxt_state = S_REQ;
        end
      end
      S_REQ: begin
        w_nxt_cnt = r_cnt + 1'b1;
        if (mem_gnt_i) begin
          w_nxt_req = 1'b0;
          if (r_we) begin
            w_nxt_state = S_DONE;
            w_nxt_done  = 1'b1;
          end else begin
            w_nxt_state = S_WAIT_R;
          end
        end else if (w_last) begin
          w_nxt_req   = 1'b0;
          w_nxt_err   = 1'b1;
          w_nxt_rdata = '0;
          w_nxt_done  = 1'b1;
          w_nxt_state = S_DONE;
        end
      end
      S_WAIT_R: begin
        w_nxt_cnt = r_cnt + 1'b1;
        if (mem_rvalid_i) begin
          w_nxt_rdata = mem_rdata_i;
          w_nxt_done  = 1'b1;
          w_nxt_state = S_DONE;
        end else if (w_last) begin
          w_nxt_err   = 1'b1;
          w_nxt_rdata = '0;
          w_nxt_done  = 1'b1;
          w_nxt_state = S_DONE;
        end
      end
      S_DONE: begin
        w_nxt_err   = 1'b0;
        w_nxt_state = S_IDLE;
      end
      default: begin
        w_nxt_req   = 1'b0;
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_req   <= w_nxt_req;
      r_we    <= w_nxt_we;
      r_addr  <= w_nxt_addr;
      r_wdata <= w_nxt_wdata;
      r_be    <= w_nxt_be;
      r_rdata <= w_nxt_rdata;
      r_done  <= w_nxt_done;
      r_err   <= w_nxt_err;
    end
  end

  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_be_o    = r_be;
  assign rdata_o     = r_rdata;
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule

// File: tb/tb_core_mem_access_unit.sv
// Directed bench for core_mem_access_unit with a short bus timeout.
// Table of single accesses plus reset and back-to-back sequences.
module tb_core_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid_i;
  logic        ls_we_i;
  logic [9:0]  ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic [3:0]  ls_be_i;
  logic        stall_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int total = 0;
  int bad   = 0;

  core_mem_access_unit #(
    .MEM_ADDR_WIDTH(10),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4),
    .TIMEOUT_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ls_valid_i(ls_valid_i),
    .ls_we_i(ls_we_i),
    .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i),
    .ls_be_i(ls_be_i),
    .stall_o(stall_o),
    .done_o(done_o),
    .err_o(err_o),
    .rdata_o(rdata_o),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          gw;
    int          rw;
    logic [31:0] rd;
    int          exp_done;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int cyc,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    for (int c = 0; c <= v.exp_done + 1; c++) begin
      @(negedge clk);
      ls_valid_i   = (c == 0);
      ls_we_i      = v.we;
      ls_addr_i    = v.addr;
      ls_wdata_i   = v.wdata;
      ls_be_i      = v.be;
      mem_gnt_i    = (c == 1 + v.gw);
      mem_rvalid_i = (c == 2 + v.gw + v.rw);
      mem_rdata_i  = mem_rvalid_i ? v.rd : 32'hBAD0BAD0;
      #1;
      chk($sformatf("v%0d stall", idx), c, 32'(stall_o),
          32'(c < v.exp_done));
      chk($sformatf("v%0d done", idx), c, 32'(done_o),
          32'(c == v.exp_done));
      if (c == v.exp_done) begin
        chk($sformatf("v%0d err", idx), c, 32'(err_o), 32'(v.exp_err));
        chk($sformatf("v%0d rdata", idx), c, rdata_o, v.exp_rdata);
        chk($sformatf("v%0d req_end", idx), c, 32'(mem_req_o), 0);
      end
      if (c >= 1 && c <= 1 + v.gw && c <= 4) begin
        chk($sformatf("v%0d req", idx), c, 32'(mem_req_o), 1);
        chk($sformatf("v%0d we", idx), c, 32'(mem_we_o), 32'(v.we));
        chk($sformatf("v%0d addr", idx), c, 32'(mem_addr_o), 32'(v.addr));
        chk($sformatf("v%0d wdata", idx), c, mem_wdata_o, v.wdata);
        chk($sformatf("v%0d be", idx), c, 32'(mem_be_o), 32'(v.be));
      end
    end
  endtask

  logic [7:0] b_vld;
  logic [7:0] b_gnt;
  logic [7:0] b_req;
  logic [7:0] b_done;
  logic [7:0] b_stall;
  int         n_req;

  initial begin
    rst          = 1'b1;
    ls_valid_i   = 1'b0;
    ls_we_i      = 1'b0;
    ls_addr_i    = '0;
    ls_wdata_i   = '0;
    ls_be_i      = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst req", 0, 32'(mem_req_o), 0);
    chk("rst we", 0, 32'(mem_we_o), 0);
    chk("rst addr", 0, 32'(mem_addr_o), 0);
    chk("rst wdata", 0, mem_wdata_o, 0);
    chk("rst be", 0, 32'(mem_be_o), 0);
    chk("rst rdata", 0, rdata_o, 0);
    chk("rst done", 0, 32'(done_o), 0);
    chk("rst err", 0, 32'(err_o), 0);
    chk("rst stall", 0, 32'(stall_o), 0);
    rst = 1'b0;

    // we addr wdata be gw rw rd done err rdata
    vecs[0] = '{1'b0, 10'h010, 32'h0, 4'hF, 0, 0,
                32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 10'h020, 32'h12345678, 4'b0011, 3, 99,
                32'h0, 5, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 10'h030, 32'h0, 4'hF, 0, 99,
                32'h0, 5, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 10'h040, 32'h0, 4'hF, 0, 2,
                32'hCAFEF00D, 5, 1'b0, 32'hCAFEF00D};
    vecs[4] = '{1'b1, 10'h3FF, 32'h87654321, 4'hF, 0, 99,
                32'h0, 2, 1'b0, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 10'h050, 32'h11223344, 4'b1000, 99, 99,
                32'h0, 5, 1'b1, 32'h0};
    vecs[6] = '{1'b0, 10'h060, 32'h0, 4'hF, 1, 1,
                32'hA5A55A5A, 5, 1'b0, 32'hA5A55A5A};
    vecs[7] = '{1'b0, 10'h070, 32'h0, 4'hF, 2, 0,
                32'h0F0F0F0F, 5, 1'b0, 32'h0F0F0F0F};

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset while waiting for read data; late rvalid must be ignored.
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      ls_valid_i   = (c == 0);
      ls_we_i      = 1'b0;
      ls_addr_i    = 10'h100;
      rst          = (c == 2);
      mem_gnt_i    = (c == 1);
      mem_rvalid_i = (c == 3);
      mem_rdata_i  = 32'h11112222;
      #1;
      if (c == 2) chk("rr stall_wait", c, 32'(stall_o), 1);
      if (c >= 3) begin
        chk("rr req", c, 32'(mem_req_o), 0);
        chk("rr stall", c, 32'(stall_o), 0);
        chk("rr done", c, 32'(done_o), 0);
        chk("rr rdata", c, rdata_o, 0);
      end
    end

    // Load then store, ls_valid held through the load's DONE cycle.
    b_vld   = 8'b0001_1111;
    b_gnt   = 8'b0010_0010;
    b_req   = 8'b0010_0010;
    b_done  = 8'b0100_1000;
    b_stall = 8'b0011_0111;
    n_req   = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ls_valid_i   = b_vld[c];
      ls_we_i      = (c >= 4);
      ls_addr_i    = (c >= 4) ? 10'h008 : 10'h004;
      ls_wdata_i   = 32'h55AA55AA;
      ls_be_i      = 4'b1100;
      mem_gnt_i    = b_gnt[c];
      mem_rvalid_i = (c == 2);
      mem_rdata_i  = (c == 2) ? 32'h44332211 : 32'hBAD0BAD0;
      #1;
      if (mem_req_o) n_req++;
      chk("b2b req", c, 32'(mem_req_o), 32'(b_req[c]));
      chk("b2b done", c, 32'(done_o), 32'(b_done[c]));
      chk("b2b stall", c, 32'(stall_o), 32'(b_stall[c]));
      if (c == 1) chk("b2b addr1", c, 32'(mem_addr_o), 32'h004);
      if (c == 5) begin
        chk("b2b addr2", c, 32'(mem_addr_o), 32'h008);
        chk("b2b we2", c, 32'(mem_we_o), 1);
      end
      if (c >= 3) chk("b2b rdata", c, rdata_o, 32'h44332211);
    end
    chk("b2b nreq", 8, 32'(n_req), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_mem_access_unit.md
Name: core_mem_access_unit

Overview:
- Data-memory access stage directly downstream of the execution unit.
- Takes the load/store request the execution unit produces (address, aligned write data, byte enables) and performs a req/gnt/rvalid handshake with data memory.
- Stalls the core until the access completes, then returns read data to the execution unit's memory-read input.
- Includes a bus timeout that reports an access error.

Parameters:
- MEM_ADDR_WIDTH, 10, data memory address width.
- DATA_WIDTH, 32, data word width; byte-enable width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, number of cycles spent in REQ+WAIT_R before abort; must be at least 1.
- TIMEOUT_WIDTH, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ls_valid_i  in  1  load/store instruction present (the decoder's is_loadstore).
- ls_we_i  in  1  1 = store, 0 = load.
- ls_addr_i  in  MEM_ADDR_WIDTH  address from the execution unit.
- ls_wdata_i  in  DATA_WIDTH  aligned write data from the execution unit.
- ls_be_i  in  DATA_WIDTH/8  byte enables.
- stall_o  out  1  hold PC and pipeline registers.
- done_o  out  1  one-cycle pulse when the access has finished.
- err_o  out  1  qualifies done_o: the access timed out.
- rdata_o  out  DATA_WIDTH  load result, feeds the execution unit's val_mem_data_read_i.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  MEM_ADDR_WIDTH  memory address.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_be_o  out  DATA_WIDTH/8  memory byte enables.
- mem_gnt_i  in  1  memory accepted the request.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  DATA_WIDTH  read data.

Behaviour:
- Reset state: state=IDLE. All registered outputs are 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, rdata_o, done_o, err_o. Timeout counter is 0.
- stall_o is combinational: 1 when (IDLE && ls_valid_i), or in REQ, or in WAIT_R. Otherwise 0, so stall_o=0 in DONE.
- IDLE:
  - On ls_valid_i=1, capture we/addr/wdata/be into the mem_* registers, set mem_req_o=1, clear the counter, and go to REQ.
  - mem_* outputs are registered, so the request appears on the bus the cycle after acceptance.
- REQ:
  - Hold mem_req_o and all mem_* values stable until mem_gnt_i=1.
  - On gnt, drop mem_req_o. A store goes to DONE; a load goes to WAIT_R.
- WAIT_R:
  - mem_rvalid_i is sampled only in this state; rvalid in the gnt cycle is ignored. Memory must return rvalid at least 1 cycle after gnt.
  - On rvalid, latch mem_rdata_i into rdata_o and go to DONE.
- DONE (one cycle):
  - done_o=1 and err_o holds the abort flag.
  - ls_valid_i is ignored here: it still belongs to the retiring instruction.
  - Unconditionally go to IDLE. done_o and err_o clear on leaving DONE.
- rdata_o holds its value until the next load completes. Stores do not change it.
- Timeout:
  - The counter increments each cycle in REQ or WAIT_R.
  - When the counter equals TIMEOUT_CYCLES-1 and the awaited gnt/rvalid is not present that cycle, set err, set rdata_o=0, drop mem_req_o, and go to DONE.
  - A gnt/rvalid arriving on the final cycle wins over the timeout.
- Latency with a zero-wait memory (gnt the same cycle req is seen, rvalid one cycle after gnt):
  - Load: accept at cycle 0, req at 1, rvalid at 2, DONE at 3.
  - Store: accept at cycle 0, req/gnt at 1, DONE at 2.
- Reset mid-access: on the next edge the state is IDLE and mem_req_o=0. Any late gnt/rvalid is ignored.
- Back-to-back accesses: a new ls_valid_i is accepted in the IDLE cycle that follows DONE, so there is at least 1 idle cycle between accesses.

Test Plan:
- Load, zero-wait: ls_valid_i=1, we=0, addr=0x010, mem_rdata_i=0xDEADBEEF returned with rvalid 1 cycle after gnt -> stall_o high for cycles 0–2; done_o pulses at cycle 3; rdata_o=0xDEADBEEF; err_o=0.
- Store with 3 cycles of gnt backpressure: wdata=0x12345678, be=4'b0011 -> mem_* stable for all 3 cycles while mem_req_o=1; done_o the cycle after gnt; rdata_o unchanged.
- Read timeout with TIMEOUT_CYCLES=4: gnt given, rvalid never arrives -> after 4 counted cycles, done_o=1, err_o=1, rdata_o=0, mem_req_o=0, and the FSM is back in IDLE next cycle.
- Boundary: rvalid on the final allowed cycle -> err_o=0 and data is latched.
- Reset mid-access: rst asserted in WAIT_R, then rvalid=1 -> after the edge mem_req_o=0, stall_o=0, done_o never pulses, rdata_o=0.
- Back-to-back: load at 0x004 then store at 0x008 with ls_valid_i held through DONE -> exactly 2 requests issued, no duplicate request, one idle cycle between them.
